// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: instruction word
// geometry, the HLT opcode, the loader state encoding and an opcode helper.
// When IMEM_LOADER_CHECKSUM_EN is defined the state set gains the two
// checksum-byte states.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned BYTE_W  = 8;

  // Opcode field of an instruction word
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam logic [3:0]  OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_HI = 3'd1,
    ST_GET_LO = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    ST_GET_CK_HI = 3'd6,
    ST_GET_CK_LO = 3'd7
`endif
  } ld_state_e;

  // True when the word carries the HLT opcode
  function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
    return word[OP_MSB:OP_LSB] == OP_HLT;
  endfunction

endpackage

// File: rtl/imem_loader_checksum.sv
// -----------------------------------------------------------------------------
// ld_checksum
// 16-bit modulo-2^16 accumulator of written instruction words. Only
// instantiated by imem_loader when IMEM_LOADER_CHECKSUM_EN is defined.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       clear the running sum (takes priority over add_i)
//   add_i       add word_i into the running sum
//   word_i      word to accumulate
//   cmp_i       reference checksum to compare against
//   sum_o       registered running sum
//   eq_c        combinational: sum_o == cmp_i
// -----------------------------------------------------------------------------
module ld_checksum
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               add_i,
  input  logic [INSTR_W-1:0] word_i,
  input  logic [INSTR_W-1:0] cmp_i,
  output logic [INSTR_W-1:0] sum_o,
  output logic               eq_c
);

  logic [INSTR_W-1:0] sum_q, sum_d;

  // Next sum: clear wins, otherwise wrap-around add
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + word_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;
  assign eq_c  = (sum_q == cmp_i);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a byte stream (valid/ready), packs byte pairs big-endian into
// 16-bit instructions and writes them sequentially into instruction memory
// starting at BASE_ADDR. The CPU is held in reset while loading and released
// one cycle after the loader enters DONE, which follows the HLT write.
// Exceeding MAX_WORDS without an HLT aborts the session into ERR.
//
// Optional feature IMEM_LOADER_CHECKSUM_EN: after the HLT write two more
// bytes (big-endian) are compared with the running sum of all written words;
// a mismatch aborts into ERR. Adds the checksum output port.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse that starts a session (IDLE/DONE/ERR only)
//   byte_in      stream byte, transferred when byte_valid && byte_ready
//   byte_valid   byte_in is valid
//   byte_ready   loader accepts a byte this cycle (depends on state only)
//   mem_wr_en    memory write request, held until mem_ready
//   mem_addr     write byte address
//   mem_wdata    instruction word
//   mem_ready    memory accepts the write this cycle
//   cpu_rst_n    active-low CPU reset
//   busy         session in progress
//   done         load completed (HLT written)
//   err          load aborted
//   word_count   words written this session
//   checksum     running word sum (IMEM_LOADER_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        MAX_WORDS = 1024,
  localparam int unsigned       CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic               mem_ready,
  output logic               cpu_rst_n,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [INSTR_W-1:0] checksum
`endif
);

  ld_state_e          state_q, state_d;
  logic               byte_ready_q, byte_ready_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               begin_session;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  ck_hi_q, ck_hi_d;
  logic               ck_clr_c;
  logic               ck_add_c;
  logic               ck_eq_c;
  logic [INSTR_W-1:0] ck_sum;

  // Compare sees the high checksum byte already captured and the low byte live
  ld_checksum u_checksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (ck_clr_c),
    .add_i  (ck_add_c),
    .word_i (wdata_q),
    .cmp_i  ({ck_hi_q, byte_in}),
    .sum_o  (ck_sum),
    .eq_c   (ck_eq_c)
  );

  assign checksum = ck_sum;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cpu_rst_n_d   = cpu_rst_n_q;
    busy_d        = busy_q;
    done_d        = done_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q + CNT_W'(1);
    begin_session = 1'b0;
    byte_ready_d  = 1'b0;
    wr_en_d       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    ck_hi_d       = ck_hi_q;
    ck_clr_c      = 1'b0;
    ck_add_c      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        begin_session = start;
      end

      ST_GET_HI: begin
        if (byte_valid) begin
          wdata_d[INSTR_W-1:BYTE_W] = byte_in;
          state_d                   = ST_GET_LO;
        end
      end

      ST_GET_LO: begin
        if (byte_valid) begin
          wdata_d[BYTE_W-1:0] = byte_in;
          state_d             = ST_WRITE;
        end
      end

      // Address/data stay frozen in the registers until the memory accepts
      ST_WRITE: begin
        if (mem_ready) begin
          cnt_d  = cnt_inc;
          addr_d = addr_q + ADDR_W'(2);
`ifdef IMEM_LOADER_CHECKSUM_EN
          ck_add_c = 1'b1;
`endif
          if (is_hlt(wdata_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_GET_CK_HI;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end else if (cnt_inc == CNT_W'(MAX_WORDS)) begin
            // Word budget exhausted without HLT
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_GET_HI;
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_GET_CK_HI: begin
        if (byte_valid) begin
          ck_hi_d = byte_in;
          state_d = ST_GET_CK_LO;
        end
      end

      ST_GET_CK_LO: begin
        if (byte_valid) begin
          busy_d = 1'b0;
          if (ck_eq_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif

      // CPU released one cycle after entry, since this state is registered
      ST_DONE: begin
        cpu_rst_n_d   = 1'b1;
        begin_session = start;
      end

      ST_ERR: begin
        begin_session = start;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new session overrides whatever the terminal state decided
    if (begin_session) begin
      state_d     = ST_GET_HI;
      cnt_d       = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      addr_d      = BASE_ADDR;
      cpu_rst_n_d = 1'b0;
      busy_d      = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ck_clr_c    = 1'b1;
`endif
    end

    // Handshake outputs are registered decodes of the next state
`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_ready_d = (state_d == ST_GET_HI)    || (state_d == ST_GET_LO) ||
                   (state_d == ST_GET_CK_HI) || (state_d == ST_GET_CK_LO);
`else
    byte_ready_d = (state_d == ST_GET_HI) || (state_d == ST_GET_LO);
`endif
    wr_en_d = (state_d == ST_WRITE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Captured high byte of the received checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_hi_q <= '0;
    end else begin
      ck_hi_q <= ck_hi_d;
    end
  end
`endif

  assign byte_ready = byte_ready_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader (MAX_WORDS=4). Word transfers come from a
// vector table with hand-computed addresses and counts; reset, restart,
// overflow and checksum corners are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int unsigned MAXW  = 4;
  localparam int unsigned CNT_W = $clog2(MAXW + 1);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             mem_wr_en;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic             mem_ready;
  logic             cpu_rst_n;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0]      checksum;
`endif

  imem_loader #(
    .ADDR_W    (16),
    .BASE_ADDR (16'h0000),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       hi;
    logic [7:0]       lo;
    int unsigned      stall;   // cycles mem_ready is held low in WRITE
    bit               bubble;  // idle cycle before the high byte, valid high in WRITE
    logic [15:0]      addr;    // expected write address
    logic [CNT_W-1:0] cnt;     // expected word_count after the write
  } vec_t;

  vec_t        vecs[10];
  int          tests;
  int          fails;
  logic [15:0] ck_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_byte_ready", 32'(byte_ready), 0);
    chk("rst_wr_en",      32'(mem_wr_en), 0);
    chk("rst_addr",       32'(mem_addr), 32'h0000);
    chk("rst_wdata",      32'(mem_wdata), 32'h0000);
    chk("rst_cpu_rst_n",  32'(cpu_rst_n), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_done",       32'(done), 0);
    chk("rst_err",        32'(err), 0);
    chk("rst_count",      32'(word_count), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("rst_checksum",   32'(checksum), 0);
`endif
  endtask

  task automatic start_session();
    start = 1'b1;
    step();
    start = 1'b0;
    ck_model = 16'h0000;
    chk("start_busy",      32'(busy), 1);
    chk("start_done",      32'(done), 0);
    chk("start_err",       32'(err), 0);
    chk("start_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("start_count",     32'(word_count), 0);
    chk("start_addr",      32'(mem_addr), 32'h0000);
    chk("start_ready",     32'(byte_ready), 1);
  endtask

  // Two bytes in, one write out, with optional stall and valid toggling
  task automatic send_word(input vec_t v);
    logic [15:0] w;
    w = {v.hi, v.lo};
    mem_ready = (v.stall == 0);
    if (v.bubble) begin
      byte_valid = 1'b0;
      byte_in    = 8'h55;
      chk("bubble_ready", 32'(byte_ready), 1);
      step();
    end
    chk("hi_ready", 32'(byte_ready), 1);
    chk("hi_wr_en", 32'(mem_wr_en), 0);
    byte_valid = 1'b1;
    byte_in    = v.hi;
    step();
    chk("lo_ready", 32'(byte_ready), 1);
    byte_in = v.lo;
    step();
    byte_valid = v.bubble;
    byte_in    = 8'hAA;
    for (int i = 0; i < int'(v.stall); i++) begin
      chk("stall_wr_en", 32'(mem_wr_en), 1);
      chk("stall_addr",  32'(mem_addr), 32'(v.addr));
      chk("stall_data",  32'(mem_wdata), 32'(w));
      chk("stall_ready", 32'(byte_ready), 0);
      step();
    end
    mem_ready = 1'b1;
    chk("wr_en",    32'(mem_wr_en), 1);
    chk("wr_addr",  32'(mem_addr), 32'(v.addr));
    chk("wr_data",  32'(mem_wdata), 32'(w));
    chk("wr_ready", 32'(byte_ready), 0);
    step();
    byte_valid = 1'b0;
    ck_model   = ck_model + w;
    chk("post_wr_en", 32'(mem_wr_en), 0);
    chk("post_count", 32'(word_count), 32'(v.cnt));
  endtask

  // After the HLT write: (checksum bytes, then) DONE and delayed CPU release
  task automatic finish_done();
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("ck_wait_done", 32'(done), 0);
    chk("ck_ready",     32'(byte_ready), 1);
    byte_valid = 1'b1;
    byte_in    = ck_model[15:8];
    step();
    byte_in = ck_model[7:0];
    step();
    byte_valid = 1'b0;
`endif
    chk("done_set",      32'(done), 1);
    chk("done_busy",     32'(busy), 0);
    chk("done_cpu_hold", 32'(cpu_rst_n), 0);
    chk("done_ready",    32'(byte_ready), 0);
    step();
    chk("done_cpu_rel",  32'(cpu_rst_n), 1);
    chk("done_hold",     32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    ck_model = 16'h0000;
    // Basic load, mem_ready always 1
    vecs[0] = '{8'h12, 8'h34, 0, 1'b0, 16'h0000, 3'd1};
    vecs[1] = '{8'h80, 8'h04, 0, 1'b0, 16'h0002, 3'd2};
    vecs[2] = '{8'hF0, 8'h00, 0, 1'b0, 16'h0004, 3'd3};
    // Same stream under backpressure
    vecs[3] = '{8'h12, 8'h34, 3, 1'b1, 16'h0000, 3'd1};
    vecs[4] = '{8'h80, 8'h04, 3, 1'b1, 16'h0002, 3'd2};
    vecs[5] = '{8'hF0, 8'h00, 3, 1'b1, 16'h0004, 3'd3};
    // Overflow: non-HLT words up to MAX_WORDS=4
    vecs[6] = '{8'h00, 8'h00, 0, 1'b0, 16'h0000, 3'd1};
    vecs[7] = '{8'h00, 8'h00, 0, 1'b0, 16'h0002, 3'd2};
    vecs[8] = '{8'h00, 8'h00, 0, 1'b0, 16'h0004, 3'd3};
    vecs[9] = '{8'h00, 8'h00, 1, 1'b0, 16'h0006, 3'd4};

    rst_n      = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    mem_ready  = 1'b0;
    #3 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_reset();
    step();
    check_reset();

    // Basic load
    start_session();
    for (int i = 0; i < 3; i++) send_word(vecs[i]);
    finish_done();
    chk("basic_count", 32'(word_count), 3);
    chk("basic_addr",  32'(mem_addr), 32'h0006);

    // Backpressure, started from DONE
    start_session();
    for (int i = 3; i < 6; i++) send_word(vecs[i]);
    finish_done();

    // Overflow
    start_session();
    for (int i = 6; i < 10; i++) send_word(vecs[i]);
    chk("ovf_err",       32'(err), 1);
    chk("ovf_done",      32'(done), 0);
    chk("ovf_busy",      32'(busy), 0);
    chk("ovf_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("ovf_ready",     32'(byte_ready), 0);
    byte_valid = 1'b1;
    byte_in    = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_no_accept", 32'(byte_ready), 0);
      chk("ovf_no_write",  32'(mem_wr_en), 0);
      chk("ovf_count",     32'(word_count), 4);
      chk("ovf_cpu_hold",  32'(cpu_rst_n), 0);
    end
    byte_valid = 1'b0;

    // Reset after three bytes, then a fresh load from BASE_ADDR
    start_session();
    send_word('{8'h12, 8'h34, 0, 1'b0, 16'h0000, 3'd1});
    byte_valid = 1'b1;
    byte_in    = 8'h56;
    step();
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset();
    step();
    rst_n = 1'b1;
    step();
    check_reset();
    start_session();
    send_word('{8'hAB, 8'hCD, 0, 1'b0, 16'h0000, 3'd1});
    send_word('{8'hF1, 8'h23, 0, 1'b0, 16'h0002, 3'd2});
    finish_done();

    // start in GET_LO must not disturb the word in progress
    start_session();
    byte_valid = 1'b1;
    byte_in    = 8'h11;
    step();
    byte_valid = 1'b0;
    start      = 1'b1;
    step();
    start = 1'b0;
    chk("ign_ready", 32'(byte_ready), 1);
    chk("ign_busy",  32'(busy), 1);
    byte_valid = 1'b1;
    byte_in    = 8'h22;
    step();
    byte_valid = 1'b0;
    mem_ready  = 1'b1;
    chk("ign_wr_en", 32'(mem_wr_en), 1);
    chk("ign_data",  32'(mem_wdata), 32'h1122);
    chk("ign_addr",  32'(mem_addr), 32'h0000);
    step();
    ck_model = ck_model + 16'h1122;
    chk("ign_count", 32'(word_count), 1);
    send_word('{8'hF0, 8'h01, 0, 1'b0, 16'h0002, 3'd2});
    finish_done();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Matching checksum 0x1234 + 0xF000 = 0x0234
    start_session();
    send_word('{8'h12, 8'h34, 0, 1'b0, 16'h0000, 3'd1});
    send_word('{8'hF0, 8'h00, 0, 1'b0, 16'h0002, 3'd2});
    chk("ck_sum", 32'(checksum), 32'h0234);
    byte_valid = 1'b1;
    byte_in    = 8'h02;
    step();
    byte_in = 8'h34;
    step();
    byte_valid = 1'b0;
    chk("ck_ok_done", 32'(done), 1);
    chk("ck_ok_err",  32'(err), 0);
    chk("ck_ok_sum",  32'(checksum), 32'h0234);

    // Mismatching checksum
    start_session();
    chk("ck_clr", 32'(checksum), 0);
    send_word('{8'h12, 8'h34, 0, 1'b0, 16'h0000, 3'd1});
    send_word('{8'hF0, 8'h00, 0, 1'b0, 16'h0002, 3'd2});
    byte_valid = 1'b1;
    byte_in    = 8'h02;
    step();
    byte_in = 8'h35;
    step();
    byte_valid = 1'b0;
    chk("ck_bad_err",  32'(err), 1);
    chk("ck_bad_done", 32'(done), 0);
    chk("ck_bad_cpu",  32'(cpu_rst_n), 0);
    step();
    chk("ck_bad_cpu2", 32'(cpu_rst_n), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the instruction fetch/decode path.
- Receives a byte stream with a valid/ready handshake, packs bytes big-endian into 16-bit instructions, and writes them sequentially into instruction memory.
- Holds the CPU in reset while loading. Releases it once the HLT instruction (opcode 4'b1111) has been written.
- Sits between the host/debug byte link and the instruction memory write port.

Parameters:
- ADDR_W, 16, instruction memory address width (byte addresses).
- BASE_ADDR, 16'h0000, address of the first word written; must be even.
- MAX_WORDS, 1024, maximum words accepted before an overflow error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- mem_wr_en  out  1  instruction memory write request
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  16  instruction word
- mem_ready  in  1  memory accepts the write this cycle
- cpu_rst_n  out  1  active-low reset to the CPU core
- busy  out  1  a load session is in progress
- done  out  1  load completed; HLT has been written
- err  out  1  load aborted (overflow, or checksum mismatch with the feature enabled)
- word_count  out  $clog2(MAX_WORDS+1)  number of words written this session

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state=IDLE
  - byte_ready=0, mem_wr_en=0, mem_addr=BASE_ADDR, mem_wdata=0
  - cpu_rst_n=0, busy=0, done=0, err=0, word_count=0
- States and transitions:
  - IDLE: wait for start.
  - GET_HI: byte_ready=1; the accepted byte goes to mem_wdata[15:8].
  - GET_LO: byte_ready=1; the accepted byte goes to mem_wdata[7:0].
  - WRITE: mem_wr_en=1 and holds until mem_ready.
  - DONE: load complete.
  - ERR: load aborted.
- A byte is transferred when byte_valid && byte_ready in the same cycle. byte_ready is combinational from state only; it never depends on byte_valid.
- start in IDLE, DONE or ERR:
  - go to GET_HI; clear word_count, done and err
  - set mem_addr=BASE_ADDR, cpu_rst_n=0, busy=1
- start in any other state is ignored.
- GET_HI --accept--> GET_LO --accept--> WRITE. The minimum is 1 cycle per byte with no bubbles.
- WRITE:
  - mem_addr, mem_wdata and mem_wr_en stay stable until mem_ready=1.
  - On the mem_ready cycle: word_count+=1, and mem_addr+=2 (wraps modulo 2^ADDR_W).
  - If mem_wdata[15:12]==4'hF (HLT), go to DONE. Otherwise go to GET_HI.
- Overflow: if word_count reaches MAX_WORDS on a write that is not HLT, go to ERR. No further bytes are accepted.
- DONE: done=1, busy=0, cpu_rst_n=1 (registered; released the cycle after entry).
- ERR: err=1, busy=0, cpu_rst_n stays 0.
- mem_wr_en is never asserted outside WRITE. Exactly one write per word.
- rst_n asserted mid-session: immediate return to reset values. The partially loaded image is not cleaned up.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN
- Enabled:
  - A 16-bit running sum (mod 2^16) of every written word, including the HLT word, is maintained.
  - After the HLT write, the FSM enters GET_CK_HI/GET_CK_LO and accepts two more bytes (big-endian checksum).
  - Match: go to DONE. Mismatch: go to ERR.
  - Adds output checksum[15:0] (the running sum; reset 0, cleared on start).
- Disabled: DONE directly after the HLT write; no checksum port and no extra states.

Decomposition:
- Package imem_loader_pkg:
  - OP_HLT = 4'hF, opcode field position [15:12]
  - loader state enum typedef
  - INSTR_W = 16
- Sub-module ld_checksum: 16-bit accumulator with clear, add-enable and compare output. Instantiated only under IMEM_LOADER_CHECKSUM_EN.

Test Plan:
- Basic load: start, then bytes 0x12,0x34,0x80,0x04,0xF0,0x00 with mem_ready always 1.
  - Required: writes 0x1234@0x0000, 0x8004@0x0002, 0xF000@0x0004; word_count=3; done=1; cpu_rst_n=1 one cycle after DONE.
- Backpressure: same stream with mem_ready low for 3 cycles per write and byte_valid toggling.
  - Required: identical writes, addr/data stable while stalled, byte_ready=0 during WRITE.
- Overflow: MAX_WORDS=4, stream 5 non-HLT words (0x0000).
  - Required: 4 writes, err=1, cpu_rst_n=0, no byte accepted after entry to ERR.
- Reset mid-session: rst_n low after 3 bytes.
  - Required: all outputs at reset values immediately. A new start then writes from BASE_ADDR with word_count=0.
- Restart: start during GET_LO is ignored; start in DONE begins a new session with done cleared and cpu_rst_n=0.
- With IMEM_LOADER_CHECKSUM_EN: words 0x1234,0xF000.
  - Checksum bytes 0x02,0x34: required done=1, checksum=0x0234.
  - Checksum bytes 0x02,0x35: required err=1, cpu_rst_n=0.
